// File: rtl/core_io_arbiter.sv
// Shared-stream I/O arbiter for the core array: round-robin input word grants
// and a round-robin output serializer feeding one tagged sink stream.
module core_io_arbiter #(
   parameter int NCORES = 25,
   parameter int DW     = 32,
   parameter int IDW    = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DW-1:0]        src_data,
   input  logic                 src_valid,
   output logic                 src_ready,
   input  logic [2*NCORES-1:0]  req_in,
   output logic [DW-1:0]        core_in,
   output logic [NCORES-1:0]    in_gnt,
   input  logic [DW*NCORES-1:0] core_out,
   input  logic [2*NCORES-1:0]  out_en,
   output logic [NCORES-1:0]    out_ack,
   output logic [DW-1:0]        sink_data,
   output logic [IDW-1:0]       sink_id,
   output logic                 sink_valid,
   input  logic                 sink_ready,
   output logic [31:0]          in_count,
   output logic [31:0]          out_count
);

   localparam logic [NCORES-1:0] ONE = NCORES'(1);

   logic [DW-1:0]     r_core_in;
   logic [NCORES-1:0] r_in_gnt;
   logic [IDW-1:0]    r_in_ptr;
   logic [31:0]       r_in_count;
   logic [NCORES-1:0] r_out_ack;
   logic [DW-1:0]     r_sink_data;
   logic [IDW-1:0]    r_sink_id;
   logic              r_sink_valid;
   logic [IDW-1:0]    r_out_ptr;
   logic [31:0]       r_out_count;

   logic [NCORES-1:0] w_in_elig;
   logic [NCORES-1:0] w_out_elig;
   logic [DW-1:0]     w_words [NCORES];
   logic [IDW:0]      w_in_pick;
   logic [IDW:0]      w_out_pick;
   logic              w_in_found;
   logic              w_out_found;
   logic [IDW-1:0]    w_in_win;
   logic [IDW-1:0]    w_out_win;
   logic              w_cap_ok;

   // First eligible index at or above ptr, wrapping; MSB of result flags a hit.
   function automatic logic [IDW:0] rr_pick(input logic [NCORES-1:0] elig,
                                            input logic [IDW-1:0] ptr);
      logic [IDW:0] res;
      logic         found;
      int           j;
      res   = '0;
      found = 1'b0;
      for (int i = 0; i < NCORES; i++) begin
         j = int'(ptr) + i;
         if (j >= NCORES) j = j - NCORES;
         if (!found && elig[j[IDW-1:0]]) begin
            found = 1'b1;
            res   = {1'b1, j[IDW-1:0]};
         end
      end
      return res;
   endfunction

   function automatic logic [IDW-1:0] ptr_next(input logic [IDW-1:0] p);
      return (p == IDW'(NCORES-1)) ? '0 : p + IDW'(1);
   endfunction

   for (genvar g = 0; g < NCORES; g++) begin : g_core
      assign w_in_elig[g]  = (req_in[2*g +: 2] != 2'b00) && !r_in_gnt[g];
      assign w_out_elig[g] = (out_en[2*g +: 2] != 2'b00) && !r_out_ack[g];
      assign w_words[g]    = core_out[DW*g +: DW];
   end

   assign w_in_pick   = rr_pick(w_in_elig, r_in_ptr);
   assign w_out_pick  = rr_pick(w_out_elig, r_out_ptr);
   assign w_in_found  = w_in_pick[IDW];
   assign w_in_win    = w_in_pick[IDW-1:0];
   assign w_out_found = w_out_pick[IDW];
   assign w_out_win   = w_out_pick[IDW-1:0];
   assign w_cap_ok    = !r_sink_valid || sink_ready;

   // Ready must never look at src_valid, so it is purely the arbiter hit.
   assign src_ready = w_in_found;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_core_in  <= '0;
         r_in_gnt   <= '0;
         r_in_ptr   <= '0;
         r_in_count <= '0;
      end else begin
         r_in_gnt <= '0;
         if (src_valid && w_in_found) begin
            r_core_in  <= src_data;
            r_in_gnt   <= ONE << w_in_win;
            r_in_ptr   <= ptr_next(w_in_win);
            r_in_count <= r_in_count + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_ack    <= '0;
         r_sink_data  <= '0;
         r_sink_id    <= '0;
         r_sink_valid <= 1'b0;
         r_out_ptr    <= '0;
         r_out_count  <= '0;
      end else begin
         r_out_ack <= '0;
         if (r_sink_valid && sink_ready) r_out_count <= r_out_count + 32'd1;
         if (w_cap_ok) begin
            if (w_out_found) begin
               r_sink_data  <= w_words[w_out_win];
               r_sink_id    <= w_out_win;
               r_sink_valid <= 1'b1;
               r_out_ack    <= ONE << w_out_win;
               r_out_ptr    <= ptr_next(w_out_win);
            end else begin
               r_sink_valid <= 1'b0;
            end
         end
      end
   end

   assign core_in    = r_core_in;
   assign in_gnt     = r_in_gnt;
   assign in_count   = r_in_count;
   assign out_ack    = r_out_ack;
   assign sink_data  = r_sink_data;
   assign sink_id    = r_sink_id;
   assign sink_valid = r_sink_valid;
   assign out_count  = r_out_count;

endmodule

// File: tb/tb_core_io_arbiter.sv
// Directed bench for core_io_arbiter; grant/capture order is checked against
// queues of expected (core, word) pairs filled when requests are driven.
module tb_core_io_arbiter;

   localparam int NCORES = 25;
   localparam int DW     = 32;
   localparam int IDW    = 5;

   typedef struct {
      int          id;
      logic [31:0] data;
   } exp_t;

   logic                 clk;
   logic                 rst;
   logic [DW-1:0]        src_data;
   logic                 src_valid;
   logic                 src_ready;
   logic [2*NCORES-1:0]  req_in;
   logic [DW-1:0]        core_in;
   logic [NCORES-1:0]    in_gnt;
   logic [DW*NCORES-1:0] core_out;
   logic [2*NCORES-1:0]  out_en;
   logic [NCORES-1:0]    out_ack;
   logic [DW-1:0]        sink_data;
   logic [IDW-1:0]       sink_id;
   logic                 sink_valid;
   logic                 sink_ready;
   logic [31:0]          in_count;
   logic [31:0]          out_count;

   int          checks = 0;
   int          errors = 0;
   int          nxt;
   logic [NCORES-1:0] hold_req;
   logic [4:0]  pat;
   exp_t        in_q[$];
   exp_t        out_q[$];

   core_io_arbiter #(.NCORES(NCORES), .DW(DW), .IDW(IDW)) dut (
      .clk(clk), .rst(rst),
      .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
      .req_in(req_in), .core_in(core_in), .in_gnt(in_gnt),
      .core_out(core_out), .out_en(out_en), .out_ack(out_ack),
      .sink_data(sink_data), .sink_id(sink_id), .sink_valid(sink_valid),
      .sink_ready(sink_ready), .in_count(in_count), .out_count(out_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] oh(input int id);
      return 32'd1 << id;
   endfunction

   // One cycle: sample at the falling edge, score pulses, and let cores drop
   // their requests/enables after their pulse.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (in_gnt != '0) begin
         if (in_q.size() == 0) chk("in_unexpected", 32'(in_gnt), 32'd0);
         else begin
            e = in_q.pop_front();
            chk("in_gnt", 32'(in_gnt), oh(e.id));
            chk("core_in", core_in, e.data);
         end
         for (int k = 0; k < NCORES; k++)
            if (in_gnt[k] && !hold_req[k]) req_in[2*k +: 2] = 2'b00;
         src_data = src_data + 32'd1;
      end
      if (out_ack != '0) begin
         if (out_q.size() == 0) chk("out_unexpected", 32'(out_ack), 32'd0);
         else begin
            e = out_q.pop_front();
            chk("out_ack", 32'(out_ack), oh(e.id));
            chk("sink_id", 32'(sink_id), 32'(e.id));
            chk("sink_data", sink_data, e.data);
         end
         for (int k = 0; k < NCORES; k++)
            if (out_ack[k]) out_en[2*k +: 2] = 2'b00;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (in_q.size() != 0 || out_q.size() != 0); i++) tick();
      chk("drain_in_q", 32'(in_q.size()), 32'd0);
      chk("drain_out_q", 32'(out_q.size()), 32'd0);
   endtask

   task automatic push_in(input int id);
      in_q.push_back('{id, 32'(nxt)});
      nxt++;
   endtask

   initial begin
      rst = 1'b0; src_data = '0; src_valid = 1'b0; req_in = '0;
      core_out = '0; out_en = '0; sink_ready = 1'b0; hold_req = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // a word parked in the sink, then reset mid-stream
      core_out[5*DW +: DW] = 32'd55;
      out_en[2*5 +: 2] = 2'b01;
      out_q.push_back('{5, 32'd55});
      tick();
      chk("pre_rst_valid", 32'(sink_valid), 32'd1);
      tick();
      #1 rst = 1'b0;
      #1;
      chk("rst_sink_valid", 32'(sink_valid), 32'd0);
      chk("rst_sink_data", sink_data, 32'd0);
      chk("rst_sink_id", 32'(sink_id), 32'd0);
      chk("rst_out_ack", 32'(out_ack), 32'd0);
      chk("rst_in_gnt", 32'(in_gnt), 32'd0);
      chk("rst_core_in", core_in, 32'd0);
      chk("rst_in_count", in_count, 32'd0);
      chk("rst_out_count", out_count, 32'd0);
      chk("rst_src_ready", 32'(src_ready), 32'd0);
      rst = 1'b1;

      // all cores offer k*100 back to back
      for (int k = 0; k < NCORES; k++) begin
         core_out[k*DW +: DW] = 32'(k * 100);
         out_en[2*k +: 2] = 2'b10;
         out_q.push_back('{k, 32'(k * 100)});
      end
      sink_ready = 1'b1;
      for (int i = 0; i < NCORES; i++) begin
         tick();
         chk("b2b_valid", 32'(sink_valid), 32'd1);
      end
      tick();
      chk("b2b_idle", 32'(sink_valid), 32'd0);
      chk("b2b_out_count", out_count, 32'd25);
      chk("b2b_out_q", 32'(out_q.size()), 32'd0);

      // output stall with cores 1 and 2
      sink_ready = 1'b0;
      core_out[1*DW +: DW] = 32'hFFFF_FFFB;
      core_out[2*DW +: DW] = 32'd7;
      out_en[2*1 +: 2] = 2'b01;
      out_en[2*2 +: 2] = 2'b11;
      out_q.push_back('{1, 32'hFFFF_FFFB});
      out_q.push_back('{2, 32'd7});
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_ack", 32'(out_ack), 32'd0);
         chk("stall_data", sink_data, 32'hFFFF_FFFB);
         chk("stall_id", 32'(sink_id), 32'd1);
      end
      sink_ready = 1'b1;
      tick();
      chk("unstall_id", 32'(sink_id), 32'd2);
      tick();
      chk("stall_out_count", out_count, 32'd27);
      chk("stall_idle", 32'(sink_valid), 32'd0);

      // input fairness: cores 0, 3, 24 twice
      src_data = 32'd10;
      nxt = 10;
      src_valid = 1'b1;
      #1 chk("src_ready_noreq", 32'(src_ready), 32'd0);
      for (int r = 0; r < 2; r++) begin
         req_in[2*0 +: 2]  = 2'b01;
         req_in[2*3 +: 2]  = 2'b10;
         req_in[2*24 +: 2] = 2'b11;
         #1 chk("src_ready_req", 32'(src_ready), 32'd1);
         push_in(0); push_in(3); push_in(24);
         drain();
         chk("fair_in_count", in_count, 32'(3 * (r + 1)));
      end

      // move pointer to 24, then a single held requester
      req_in[2*23 +: 2] = 2'b01;
      push_in(23);
      drain();
      hold_req[24] = 1'b1;
      req_in[2*24 +: 2] = 2'b01;
      push_in(24); push_in(24); push_in(24);
      for (int i = 0; i < 5; i++) begin
         tick();
         pat[i] = in_gnt[24];
      end
      chk("hold_pattern", 32'(pat), 32'b10101);
      req_in[2*24 +: 2] = 2'b00;
      hold_req[24] = 1'b0;
      tick();
      chk("hold_release", 32'(in_gnt), 32'd0);
      chk("hold_in_q", 32'(in_q.size()), 32'd0);

      // pointer wrapped to 0: core 0 beats core 24
      req_in[2*0 +: 2]  = 2'b01;
      req_in[2*24 +: 2] = 2'b01;
      push_in(0); push_in(24);
      drain();
      chk("wrap_in_count", in_count, 32'd12);

      // in_count wrap
      force dut.r_in_count = 32'hFFFF_FFFF;
      #1 release dut.r_in_count;
      #1 chk("pre_wrap_count", in_count, 32'hFFFF_FFFF);
      req_in[2*7 +: 2] = 2'b01;
      push_in(7);
      drain();
      chk("count_wrap", in_count, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
